// File: rtl/core_pkg.sv
// core_pkg: shared types for the core load/store slice.
//   word       32-bit data/address word
//   reg_num    register-file index
//   wb_line    {ready, rd, value} result line handed to core_writeback
//   ldst_size  access width: LDST_BYTE / LDST_HALF / LDST_WORD
//   ldst_state load/store FSM states
// Helpers: align_off()       forces low address bits to size alignment
//          is_misaligned()   true when the low address bits do not suit the size
package core_pkg;

    localparam int REG_NUM_W = 5;

    typedef logic [31:0]          word;
    typedef logic [REG_NUM_W-1:0] reg_num;

    typedef struct packed {
        logic   ready;
        reg_num rd;
        word    value;
    } wb_line;

    typedef enum logic [1:0] {
        LDST_BYTE = 2'd0,
        LDST_HALF = 2'd1,
        LDST_WORD = 2'd2
    } ldst_size;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WB   = 2'd2
    } ldst_state;

    // Drop address bits that lie below the access size; an unknown size is handled as a word.
    function automatic logic [1:0] align_off(input ldst_size size, input logic [1:0] off);
        logic [1:0] res;
        case (size)
            LDST_BYTE: res = off;
            LDST_HALF: res = {off[1], 1'b0};
            LDST_WORD: res = 2'b00;
            default:   res = 2'b00;
        endcase
        return res;
    endfunction

    function automatic logic is_misaligned(input ldst_size size, input logic [1:0] off);
        logic res;
        case (size)
            LDST_BYTE: res = 1'b0;
            LDST_HALF: res = off[0];
            LDST_WORD: res = (off != 2'b00);
            default:   res = (off != 2'b00);
        endcase
        return res;
    endfunction

endpackage

// File: rtl/core_ldst_lane.sv
// core_ldst_lane: combinational byte-lane logic for the load/store unit.
//   Store side: st_size/st_off/st_data -> wdata (lane-replicated) and be (byte enables).
//   Load side:  ld_size/ld_off/ld_signed/rdata -> ld_value (shifted, truncated, extended).
//   Offsets arriving here are already size-aligned.
module core_ldst_lane
    import core_pkg::*;
(
    input  ldst_size     st_size,
    input  logic [1:0]   st_off,
    input  word          st_data,
    output word          wdata,
    output logic [3:0]   be,
    input  ldst_size     ld_size,
    input  logic [1:0]   ld_off,
    input  logic         ld_signed,
    input  word          rdata,
    output word          ld_value
);

    word shifted_s;

    // Store lanes: replicate narrow data into every lane, enable only the addressed bytes.
    always_comb begin
        wdata = st_data;
        be    = 4'b1111;
        case (st_size)
            LDST_BYTE: begin
                wdata = {4{st_data[7:0]}};
                be    = 4'b0001 << st_off;
            end
            LDST_HALF: begin
                wdata = {2{st_data[15:0]}};
                be    = 4'b0011 << st_off;
            end
            LDST_WORD: begin
                wdata = st_data;
                be    = 4'b1111;
            end
            default: begin
                wdata = st_data;
                be    = 4'b1111;
            end
        endcase
    end

    // Load path: bring the addressed bytes down to bit 0, then truncate and extend.
    always_comb begin
        shifted_s = rdata >> {ld_off, 3'b000};
        ld_value  = shifted_s;
        case (ld_size)
            LDST_BYTE: ld_value = {{24{ld_signed & shifted_s[7]}}, shifted_s[7:0]};
            LDST_HALF: ld_value = {{16{ld_signed & shifted_s[15]}}, shifted_s[15:0]};
            LDST_WORD: ld_value = shifted_s;
            default:   ld_value = shifted_s;
        endcase
    end

endmodule

// File: rtl/core_ldst.sv
// core_ldst: load/store execution unit.
//   Accepts one op in IDLE (issue_*), runs one Avalon-style bus transfer (mem_*),
//   and for loads presents the aligned/extended result on wb_ldst until
//   core_writeback takes it (wb_stall_ldst=0). Stores produce no writeback.
//   ldst_fault pulses for one cycle when the bus stalls WAIT_LIMIT cycles in a row.
// Parameters: WAIT_LIMIT - consecutive waitrequest cycles before the op aborts.
// Configuration macro: LDST_MISALIGN_CHECK_EN - when defined, a misaligned HALF/WORD
//   op is rejected at issue with a ldst_fault pulse and no bus cycle; when undefined,
//   low address bits are silently forced to size alignment.
// Reset: rst_n, synchronous, active-low. All outputs are registered.
module core_ldst
    import core_pkg::*;
#(
    parameter int WAIT_LIMIT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         issue_valid,
    output logic         issue_ready,
    input  logic         issue_store,
    input  ldst_size     issue_size,
    input  logic         issue_signed,
    input  word          issue_base,
    input  word          issue_offset,
    input  word          issue_data,
    input  reg_num       issue_rd,
    output word          mem_address,
    output logic         mem_read,
    output logic         mem_write,
    output word          mem_writedata,
    output logic [3:0]   mem_byteenable,
    input  logic         mem_waitrequest,
    input  word          mem_readdata,
    output wb_line       wb_ldst,
    input  logic         wb_stall_ldst,
    output logic         ldst_fault
);

    // Counter only has to reach WAIT_LIMIT-1: the cycle that would make it WAIT_LIMIT aborts.
    localparam int            CW        = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_LIMIT - 1);

    ldst_state     state_r;
    logic [CW-1:0] wait_cnt_r;
    ldst_size      ld_size_r;
    logic [1:0]    ld_off_r;
    logic          ld_signed_r;

    word           addr_s;
    logic [1:0]    off_s;
    logic          misalign_s;
    word           st_wdata_s;
    logic [3:0]    st_be_s;
    word           ld_value_s;

    assign addr_s = issue_base + issue_offset;
    assign off_s  = align_off(issue_size, addr_s[1:0]);

`ifdef LDST_MISALIGN_CHECK_EN
    assign misalign_s = is_misaligned(issue_size, addr_s[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    // Store lanes come from the issuing op and are registered onto the bus; the load
    // path works on the latched op so it can extract data on the acceptance cycle.
    core_ldst_lane u_lane (
        .st_size   (issue_size),
        .st_off    (off_s),
        .st_data   (issue_data),
        .wdata     (st_wdata_s),
        .be        (st_be_s),
        .ld_size   (ld_size_r),
        .ld_off    (ld_off_r),
        .ld_signed (ld_signed_r),
        .rdata     (mem_readdata),
        .ld_value  (ld_value_s)
    );

    // Load/store FSM with all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            issue_ready    <= 1'b1;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= 32'h0000_0000;
            mem_writedata  <= 32'h0000_0000;
            mem_byteenable <= 4'b0000;
            wb_ldst        <= '0;
            ldst_fault     <= 1'b0;
            wait_cnt_r     <= '0;
            ld_size_r      <= LDST_WORD;
            ld_off_r       <= 2'b00;
            ld_signed_r    <= 1'b0;
        end else begin
            ldst_fault <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    wait_cnt_r <= '0;
                    if (issue_valid) begin
                        if (misalign_s) begin
                            ldst_fault <= 1'b1;
                        end else begin
                            state_r        <= ST_REQ;
                            issue_ready    <= 1'b0;
                            mem_read       <= ~issue_store;
                            mem_write      <= issue_store;
                            mem_address    <= {addr_s[31:2], 2'b00};
                            mem_writedata  <= st_wdata_s;
                            mem_byteenable <= st_be_s;
                            ld_size_r      <= issue_size;
                            ld_off_r       <= off_s;
                            ld_signed_r    <= issue_signed;
                            wb_ldst.rd     <= issue_rd;
                        end
                    end
                end
                ST_REQ: begin
                    if (!mem_waitrequest) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (mem_read) begin
                            wb_ldst.ready <= 1'b1;
                            wb_ldst.value <= ld_value_s;
                            state_r       <= ST_WB;
                        end else begin
                            state_r     <= ST_IDLE;
                            issue_ready <= 1'b1;
                        end
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        // Bus never answered: abandon the op without a writeback.
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        ldst_fault  <= 1'b1;
                        state_r     <= ST_IDLE;
                        issue_ready <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 1'b1;
                    end
                end
                ST_WB: begin
                    if (!wb_stall_ldst) begin
                        wb_ldst.ready <= 1'b0;
                        state_r       <= ST_IDLE;
                        issue_ready   <= 1'b1;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    issue_ready   <= 1'b1;
                    mem_read      <= 1'b0;
                    mem_write     <= 1'b0;
                    wb_ldst.ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
